// File: rtl/gray_seq_ctrl_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : gray_seq_ctrl_if
// Brief    : Control/handshake bundle for gray_seq_ctrl (master = stimulus side,
//            slave = sequencer).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface gray_seq_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             stop;
    logic             dir;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] limit;
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] gray;
    logic             busy;
    logic             done;

    modport master (
        output start, stop, dir, load_val, limit, out_ready,
        input  out_valid, bin, gray, busy, done
    );

    modport slave (
        input  start, stop, dir, load_val, limit, out_ready,
        output out_valid, bin, gray, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/gray_seq_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : gray_seq_ctrl
// Brief    : Binary/Gray sequence generator with valid/ready output handshake.
//            Define GRAY_SEQ_WRAP_EN to restart from load_val at the limit
//            instead of terminating through DONE.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module gray_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    gray_seq_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [1:0]       r_rst_sync;
    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_limit;
    logic             r_dir;
    logic             r_out_valid;
    logic             r_busy;
    logic             r_done;
`ifdef GRAY_SEQ_WRAP_EN
    logic [WIDTH-1:0] r_load;
`endif

    logic             w_rst_n;
    logic             w_accept;
    logic             w_at_limit;
    logic [WIDTH-1:0] w_bin_next;
    logic [WIDTH-1:0] w_gray;

    // Reset asserts asynchronously, releases on a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n    = r_rst_sync[1];
    assign w_accept   = r_out_valid & bus.out_ready;
    assign w_at_limit = (r_bin == r_limit);
    assign w_bin_next = r_dir ? (r_bin - c_one) : (r_bin + c_one);
    assign w_gray     = r_bin ^ (r_bin >> 1);

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state     <= S_IDLE;
            r_bin       <= '0;
            r_limit     <= '0;
            r_dir       <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef GRAY_SEQ_WRAP_EN
            r_load      <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state     <= S_RUN;
                        r_bin       <= bus.load_val;
                        r_limit     <= bus.limit;
                        r_dir       <= bus.dir;
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b1;
`ifdef GRAY_SEQ_WRAP_EN
                        r_load      <= bus.load_val;
`endif
                    end
                end
                S_RUN: begin
                    // Abort wins over a beat offered in the same cycle.
                    if (bus.stop) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end else if (w_accept) begin
                        if (w_at_limit) begin
`ifdef GRAY_SEQ_WRAP_EN
                            r_bin       <= r_load;
                            r_done      <= 1'b1;
`else
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b0;
                            r_done      <= 1'b1;
`endif
                        end else begin
                            r_bin <= w_bin_next;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.bin       = r_bin;
    assign bus.gray      = w_gray;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
endmodule
`default_nettype wire

// File: tb/tb_gray_seq_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_gray_seq_ctrl
// Brief    : Directed self-checking bench for gray_seq_ctrl (WIDTH=4).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_gray_seq_ctrl;
    localparam int WIDTH = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic [3:0] eb [16];
    logic [3:0] eg [16];

    gray_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

    gray_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_busy"},  32'(bus.busy),      32'd0);
        chk({tag, "_done"},  32'(bus.done),      32'd0);
    endtask

    // Drive start for one cycle, then scramble the captured inputs.
    task automatic start_seq(input logic [3:0] lv, input logic [3:0] lim, input logic d);
        bus.start    = 1'b1;
        bus.load_val = lv;
        bus.limit    = lim;
        bus.dir      = d;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.load_val = ~lv;
        bus.limit    = lim + 4'd7;
        bus.dir      = ~d;
    endtask

    task automatic run_beats(input int n);
        for (int i = 0; i < n; i++) begin
            chk("beat_valid", 32'(bus.out_valid), 32'd1);
            chk("beat_bin",   32'(bus.bin),       32'(eb[i]));
            chk("beat_gray",  32'(bus.gray),      32'(eg[i]));
            chk("beat_busy",  32'(bus.busy),      32'd1);
            chk("beat_done",  32'(bus.done),      32'd0);
            bus.start = (i % 5 == 2);
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    task automatic expect_done();
        chk("done_pulse", 32'(bus.done),      32'd1);
        chk("done_busy",  32'(bus.busy),      32'd1);
        chk("done_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        chk_quiet("after_done");
    endtask

    task automatic fill_count_up();
        logic [3:0] gtab [16];
        gtab = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
        for (int i = 0; i < 16; i++) begin
            eb[i] = 4'(i);
            eg[i] = gtab[i];
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.dir       = 1'b0;
        bus.load_val  = 4'h0;
        bus.limit     = 4'h0;
        bus.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk_quiet("reset");
        chk("reset_bin",  32'(bus.bin),  32'd0);
        chk("reset_gray", 32'(bus.gray), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk_quiet("post_release");

`ifndef GRAY_SEQ_WRAP_EN
        // Full up-count 0..15.
        fill_count_up();
        start_seq(4'h0, 4'hF, 1'b0);
        run_beats(16);
        expect_done();

        // Same run with a three-cycle stall at bin=5.
        start_seq(4'h0, 4'hF, 1'b0);
        for (int i = 0; i < 16; i++) begin
            chk("stall_bin",  32'(bus.bin),  32'(eb[i]));
            chk("stall_gray", 32'(bus.gray), 32'(eg[i]));
            if (i == 5) begin
                bus.out_ready = 1'b0;
                bus.start     = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    chk("hold_valid", 32'(bus.out_valid), 32'd1);
                    chk("hold_bin",   32'(bus.bin),       32'd5);
                    chk("hold_gray",  32'(bus.gray),      32'h7);
                end
                bus.start     = 1'b0;
                bus.out_ready = 1'b1;
            end
            @(negedge clk);
        end
        expect_done();

        // Down-count 3 -> 0.
        eb[0] = 4'h3; eb[1] = 4'h2; eb[2] = 4'h1; eb[3] = 4'h0;
        eg[0] = 4'h2; eg[1] = 4'h3; eg[2] = 4'h1; eg[3] = 4'h0;
        start_seq(4'h3, 4'h0, 1'b1);
        run_beats(4);
        expect_done();

        // Up-count across the 15 -> 0 wrap.
        eb[0] = 4'hE; eb[1] = 4'hF; eb[2] = 4'h0; eb[3] = 4'h1;
        eg[0] = 4'h9; eg[1] = 4'h8; eg[2] = 4'h0; eg[3] = 4'h1;
        start_seq(4'hE, 4'h1, 1'b0);
        run_beats(4);
        expect_done();
`else
        // Wrapping run 2,3,4,2,3,4,... with done after each accepted 4.
        start_seq(4'h2, 4'h4, 1'b0);
        for (int i = 0; i < 9; i++) begin
            chk("wrap_bin",   32'(bus.bin),       32'(4'(2 + i % 3)));
            chk("wrap_done",  32'(bus.done),      32'((i > 0 && i % 3 == 0) ? 1 : 0));
            chk("wrap_valid", 32'(bus.out_valid), 32'd1);
            chk("wrap_busy",  32'(bus.busy),      32'd1);
            @(negedge clk);
        end
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        chk_quiet("wrap_stop");
`endif

        // Stop at bin=4 while a beat is offered.
        fill_count_up();
        start_seq(4'h0, 4'hF, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("stop_run_bin", 32'(bus.bin), 32'(eb[i]));
            if (i < 4) @(negedge clk);
        end
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        chk_quiet("stop");
        @(negedge clk);
        chk_quiet("stop_idle");

        // Asynchronous reset in the middle of a run.
        start_seq(4'h0, 4'hF, 1'b0);
        repeat (2) @(negedge clk);
        chk("pre_reset_bin", 32'(bus.bin), 32'd2);
        rst_n = 1'b0;
        #1;
        chk_quiet("async_reset");
        chk("async_reset_bin",  32'(bus.bin),  32'd0);
        chk("async_reset_gray", 32'(bus.gray), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk_quiet("reset_wait");
        end

`ifndef GRAY_SEQ_WRAP_EN
        // load_val == limit gives exactly one beat.
        eb[0] = 4'h5;
        eg[0] = 4'h7;
        start_seq(4'h5, 4'h5, 1'b0);
        run_beats(1);
        expect_done();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/gray_seq_ctrl.md
GRAY_SEQ_CTRL -- requirements
Module: gray_seq_ctrl

Interface
REQ-001 Parameter: WIDTH, 4, bit width of the binary count and Gray output.
REQ-002 Port: clk  input  1  sole clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  begin sequence; sampled only in IDLE.
REQ-005 Port: stop  input  1  abort sequence; sampled in RUN.
REQ-006 Port: dir  input  1  0 = count up, 1 = count down; captured at start.
REQ-007 Port: load_val  input  WIDTH  first binary value; captured at start.
REQ-008 Port: limit  input  WIDTH  final binary value; captured at start.
REQ-009 Port: out_ready  input  1  consumer accepts current beat.
REQ-010 Port: out_valid  output  1  gray/bin hold a valid beat.
REQ-011 Port: bin  output  WIDTH  current binary value.
REQ-012 Port: gray  output  WIDTH  Gray code of bin.
REQ-013 Port: busy  output  1  high in RUN and DONE.
REQ-014 Port: done  output  1  one-cycle pulse after the limit beat is accepted.

Function
REQ-015 FSM states SHALL be IDLE, RUN, DONE; encoding is free.
REQ-016 gray SHALL equal bin XOR (bin >> 1) at all times: MSB passes through, each lower bit = XOR of itself and next-higher bit.
REQ-017 IDLE: start=1 -> RUN next cycle; bin <= load_val; dir, load_val, limit captured; out_valid=1 from the cycle after start (latency 1).
REQ-018 start while busy SHALL be ignored.
REQ-019 RUN: out_valid=1; beat accepted when out_valid & out_ready; bin and gray SHALL hold stable while out_ready=0.
REQ-020 Accept with bin != limit: bin <= bin+1 (dir=0) or bin-1 (dir=1), modulo 2^WIDTH (15+1 -> 0, 0-1 -> 15 for WIDTH=4).
REQ-021 Accept with bin == limit: -> DONE; out_valid=0 next cycle.
REQ-022 DONE: done=1 for exactly one cycle, then IDLE; busy=1 in DONE.
REQ-023 stop=1 in RUN SHALL take priority over accept: -> IDLE next cycle, out_valid=0, done not asserted; a beat presented in that cycle counts as not transferred.
REQ-024 load_val == limit: exactly one beat, then DONE.
REQ-025 Changes on dir, load_val, limit during RUN SHALL have no effect.
REQ-026 All outputs SHALL be driven from registers or from combinational logic on registered bin only; no input-to-output combinational path.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, bin=0, gray=0, out_valid=0, busy=0, done=0, irrespective of clk.
REQ-028 Reset mid-RUN SHALL abandon the sequence; no done pulse; after release the block waits for a new start.
REQ-029 Deassertion of rst_n SHALL be synchronous to clk.

Configuration
REQ-030 Macro GRAY_SEQ_WRAP_EN defined: accept at bin == limit pulses done for one cycle while staying in RUN, reloads bin <= captured load_val, out_valid stays 1; sequence repeats until stop or reset; DONE state unused.
REQ-031 Macro GRAY_SEQ_WRAP_EN undefined: behaviour per REQ-021/REQ-022; no wrap logic synthesized.

Verification (WIDTH=4)
REQ-032 load_val=0, limit=15, dir=0, out_ready=1, start -> gray 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8 on 16 consecutive cycles, done one cycle after last beat, then IDLE.
REQ-033 Same run, out_ready low for 3 cycles at bin=5 -> gray holds 7, out_valid stays 1, sequence resumes with 5 (bin 6) without skipping.
REQ-034 load_val=3, limit=0, dir=1 -> bin 3,2,1,0 / gray 2,3,1,0, then done.
REQ-035 load_val=14, limit=1, dir=0 -> bin 14,15,0,1 / gray 9,8,0,1 (wrap-around), then done.
REQ-036 stop asserted at bin=4, then separately rst_n pulsed low mid-RUN -> out_valid=0 next cycle (stop) / immediately (reset), no done, outputs 0 after reset.
REQ-037 GRAY_SEQ_WRAP_EN, load_val=2, limit=4 -> bin 2,3,4,2,3,4,..., done pulse after each accepted 4, busy stays 1 until stop.
